cpu_sequencer: RTL and testbench

Parametrised multicycle control sequencer for the 9-bit CPU. It replaces the ad-hoc step counter with one explicit FSM. Per instruction it issues one-cycle enable strobes to fetch_unit, decoder, register, alu and memory, routed by instruction class. Over the previous generation it adds a memory ready/timeout handshake, a multi-cycle ALU wait, a clean halt/error path and a programmable start address.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/seq_timer.sv | 38 +++
 rtl/cpu_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 9-bit CPU control path:
//   - seq_state_t : states of the multicycle sequencer FSM
//   - CLS_*       : instruction class codes produced by the decoder
//   - DEF_*       : default widths / timing used as parameter defaults
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int DEF_TYPE_W      = 3;
   localparam int DEF_ADDR_W      = 9;
   localparam int DEF_ALU_CYCLES  = 1;
   localparam int DEF_MEM_TIMEOUT = 15;

   localparam int CLS_ALU  = 1;
   localparam int CLS_JMPI = 2;
   localparam int CLS_MOV  = 3;
   localparam int CLS_JMP  = 4;
   localparam int CLS_ST   = 5;
   localparam int CLS_LD   = 6;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_OPF,
      S_EXEC,
      S_MEM,
      S_WB,
      S_BRANCH,
      S_HALTED
   } seq_state_t;

endpackage

// File: rtl/seq_timer.sv
// -----------------------------------------------------------------------------
// seq_timer
// Loadable down-counter with an expiry flag. Loaded with (N-1) on the edge
// that enters a timed state, it reports expired during the N-th cycle.
// Ports:
//   clk       in   system clock
//   init_n    in   asynchronous active-low reset (count cleared to 0)
//   load      in   load load_val on the next edge (has priority over dec)
//   load_val  in   W  value to load
//   dec       in   decrement by one (holds at zero)
//   expired   out  count is zero
// -----------------------------------------------------------------------------
module seq_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         init_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         expired
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
// Multicycle control FSM for the 9-bit CPU. Issues one-cycle stage strobes
// (fetch, decode, register read, ALU, register write) routed by instruction
// class, holds memory requests until mem_ready or timeout, and ends in a
// sticky HALTED state flagged by done (HALT opcode) or err (illegal class,
// memory timeout).
// Optional build macro: SEQ_PERF_CNT_EN adds a saturating retired-instruction
// counter on the retired port; without it retired is tied to zero.
// Ports:
//   clk, init_n                 clock, asynchronous active-low reset
//   start, start_addr           begin fetching at start_addr (IDLE only)
//   inst_type, halt_inst        decoder class and HALT flag
//   mem_ready                   memory access complete
//   fetch_en .. reg_mem_w_en    one-cycle stage strobes
//   mem_r_en, mem_w_en          memory request, held until mem_ready
//   branch_en                   fetch unit takes branch/jump
//   pc_load                     fetch unit loads start_addr
//   busy, done, err             status
//   retired                     retired instruction count
// -----------------------------------------------------------------------------
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int TYPE_W      = DEF_TYPE_W,
   parameter int ALU_CYCLES  = DEF_ALU_CYCLES,
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
   parameter int ADDR_W      = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              init_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [TYPE_W-1:0] inst_type,
   input  logic              halt_inst,
   input  logic              mem_ready,
   output logic              fetch_en,
   output logic              decode_en,
   output logic              reg_r_en,
   output logic              alu_en,
   output logic              reg_w_en,
   output logic              reg_mem_w_en,
   output logic              mem_r_en,
   output logic              mem_w_en,
   output logic              branch_en,
   output logic              pc_load,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [15:0]       retired
);

   localparam int ALU_TW = $clog2(ALU_CYCLES + 1);
   localparam int MEM_TW = $clog2(MEM_TIMEOUT + 1);

   localparam logic [TYPE_W-1:0] T_ALU  = TYPE_W'(CLS_ALU);
   localparam logic [TYPE_W-1:0] T_JMPI = TYPE_W'(CLS_JMPI);
   localparam logic [TYPE_W-1:0] T_MOV  = TYPE_W'(CLS_MOV);
   localparam logic [TYPE_W-1:0] T_JMP  = TYPE_W'(CLS_JMP);
   localparam logic [TYPE_W-1:0] T_ST   = TYPE_W'(CLS_ST);
   localparam logic [TYPE_W-1:0] T_LD   = TYPE_W'(CLS_LD);

   seq_state_t        state_q, state_d;
   logic [TYPE_W-1:0] cls_q;
   logic              pc_load_q, done_q, err_q;
   logic              alu_load, alu_dec, alu_exp;
   logic              mem_load, mem_dec, mem_exp;
   logic              halt_done, halt_err, retire;
   logic              cls_is_ld;

   // Class is latched at the end of DECODE; later states route on the copy.
   assign cls_is_ld = (cls_q == T_LD);

   seq_timer #(.W(ALU_TW)) u_alu_timer (
      .clk      (clk),
      .init_n   (init_n),
      .load     (alu_load),
      .load_val (ALU_TW'(ALU_CYCLES - 1)),
      .dec      (alu_dec),
      .expired  (alu_exp)
   );

   seq_timer #(.W(MEM_TW)) u_mem_timer (
      .clk      (clk),
      .init_n   (init_n),
      .load     (mem_load),
      .load_val (MEM_TW'(MEM_TIMEOUT - 1)),
      .dec      (mem_dec),
      .expired  (mem_exp)
   );

   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state_q   <= S_IDLE;
         cls_q     <= '0;
         pc_load_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         // Registered so the pulse lines up with the first FETCH cycle.
         pc_load_q <= (state_q == S_IDLE) && start;
         if (state_q == S_DECODE) cls_q <= inst_type;
         if (halt_done) done_q <= 1'b1;
         if (halt_err)  err_q  <= 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      fetch_en     = 1'b0;
      decode_en    = 1'b0;
      reg_r_en     = 1'b0;
      alu_en       = 1'b0;
      reg_w_en     = 1'b0;
      reg_mem_w_en = 1'b0;
      mem_r_en     = 1'b0;
      mem_w_en     = 1'b0;
      branch_en    = 1'b0;
      alu_load     = 1'b0;
      alu_dec      = 1'b0;
      mem_load     = 1'b0;
      mem_dec      = 1'b0;
      halt_done    = 1'b0;
      halt_err     = 1'b0;
      retire       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            fetch_en = 1'b1;
            state_d  = S_DECODE;
         end
         S_DECODE: begin
            decode_en = 1'b1;
            if (halt_inst) begin
               state_d   = S_HALTED;
               halt_done = 1'b1;
            end else begin
               case (inst_type)
                  T_ALU, T_JMP, T_ST, T_LD: state_d = S_OPF;
                  T_JMPI:                   state_d = S_BRANCH;
                  T_MOV:                    state_d = S_WB;
                  default: begin
                     state_d  = S_HALTED;
                     halt_err = 1'b1;
                  end
               endcase
            end
         end
         S_OPF: begin
            reg_r_en = 1'b1;
            case (cls_q)
               T_ALU: begin
                  state_d  = S_EXEC;
                  alu_load = 1'b1;
               end
               T_JMP: state_d = S_BRANCH;
               T_ST, T_LD: begin
                  state_d  = S_MEM;
                  mem_load = 1'b1;
               end
               default: begin
                  state_d  = S_HALTED;
                  halt_err = 1'b1;
               end
            endcase
         end
         S_EXEC: begin
            alu_en = 1'b1;
            if (alu_exp) state_d = S_WB;
            else         alu_dec = 1'b1;
         end
         S_MEM: begin
            mem_r_en = cls_is_ld;
            mem_w_en = !cls_is_ld;
            // A ready in the last allowed cycle still completes the access.
            if (mem_ready) begin
               if (cls_is_ld) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
            end else if (mem_exp) begin
               state_d  = S_HALTED;
               halt_err = 1'b1;
            end else begin
               mem_dec = 1'b1;
            end
         end
         S_WB: begin
            reg_mem_w_en = cls_is_ld;
            reg_w_en     = !cls_is_ld;
            state_d      = S_FETCH;
            retire       = 1'b1;
         end
         S_BRANCH: begin
            branch_en = 1'b1;
            state_d   = S_FETCH;
            retire    = 1'b1;
         end
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_IDLE;
      endcase
   end

   assign pc_load = pc_load_q;
   assign done    = done_q;
   assign err     = err_q;
   assign busy    = (state_q != S_IDLE) && (state_q != S_HALTED);

   // start_addr is consumed by the fetch unit directly; the sequencer only
   // times pc_load, so the address is deliberately not used here.
   logic unused_ok;

`ifdef SEQ_PERF_CNT_EN
   logic [15:0] retired_q;

   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         retired_q <= '0;
      end else if (retire && (retired_q != 16'hFFFF)) begin
         retired_q <= retired_q + 16'd1;
      end
   end

   assign retired   = retired_q;
   assign unused_ok = ^start_addr;
`else
   assign retired   = 16'd0;
   assign unused_ok = ^{start_addr, retire};
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
// Builds the expected per-cycle output trace of each instruction from its
// class (stage list per class, ALU hold length, memory wait), then replays
// the matching inputs into cpu_sequencer and compares every cycle.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

   localparam int TYPE_W      = 3;
   localparam int ALU_CYCLES  = 3;
   localparam int MEM_TIMEOUT = 15;
   localparam int ADDR_W      = 9;

   logic              clk = 1'b0;
   logic              init_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] start_addr = '0;
   logic [TYPE_W-1:0] inst_type = '0;
   logic              halt_inst = 1'b0;
   logic              mem_ready = 1'b0;
   logic fetch_en, decode_en, reg_r_en, alu_en, reg_w_en, reg_mem_w_en;
   logic mem_r_en, mem_w_en, branch_en, pc_load, busy, done, err;
   logic [15:0] retired;

   always #5 clk = ~clk;

   cpu_sequencer #(
      .TYPE_W(TYPE_W), .ALU_CYCLES(ALU_CYCLES),
      .MEM_TIMEOUT(MEM_TIMEOUT), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .init_n(init_n), .start(start), .start_addr(start_addr),
      .inst_type(inst_type), .halt_inst(halt_inst), .mem_ready(mem_ready),
      .fetch_en(fetch_en), .decode_en(decode_en), .reg_r_en(reg_r_en),
      .alu_en(alu_en), .reg_w_en(reg_w_en), .reg_mem_w_en(reg_mem_w_en),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .branch_en(branch_en),
      .pc_load(pc_load), .busy(busy), .done(done), .err(err),
      .retired(retired)
   );

   localparam int B_FETCH = 12, B_DEC = 11, B_RR = 10, B_ALU = 9, B_RW = 8;
   localparam int B_RMW = 7, B_MR = 6, B_MW = 5, B_BR = 4, B_PCL = 3;
   localparam int B_BUSY = 2, B_DONE = 1, B_ERR = 0;

   logic [12:0] obs;
   assign obs = {fetch_en, decode_en, reg_r_en, alu_en, reg_w_en, reg_mem_w_en,
                 mem_r_en, mem_w_en, branch_en, pc_load, busy, done, err};

   typedef struct packed {
      logic [12:0] exp;
      logic [15:0] ret;
      logic [2:0]  ityp;
      logic        halt;
      logic        rdy;
      logic        start;
   } rec_t;

   rec_t       q[$];
   int         errors = 0;
   int         checks = 0;
   int         model_ret = 0;
   logic [2:0] cur_t = '0;
   logic       cur_h = 1'b0;
   bit         alive;

   function automatic logic [12:0] one(input int b);
      logic [12:0] v;
      v    = '0;
      v[b] = 1'b1;
      return v;
   endfunction

   function automatic logic [15:0] ret_now();
`ifdef SEQ_PERF_CNT_EN
      return (model_ret > 65535) ? 16'hFFFF : 16'(model_ret);
`else
      return 16'd0;
`endif
   endfunction

   task automatic chk(input string tag, input int idx, input logic [15:0] o,
                      input logic [15:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s[%0d]: observed %b expected %b", tag, idx, o, e);
      end
   endtask

   task automatic push(input logic [12:0] e, input logic rdy, input logic st);
      rec_t r;
      r.exp   = e;
      r.ret   = ret_now();
      r.ityp  = cur_t;
      r.halt  = cur_h;
      r.rdy   = rdy;
      r.start = st;
      q.push_back(r);
   endtask

   // Sticky halt: a few cycles of the final flag, one carrying a start pulse.
   task automatic add_halted(input bit by_halt);
      for (int i = 0; i < 4; i++)
         push(by_halt ? one(B_DONE) : one(B_ERR), 1'b0, (i == 1));
   endtask

   // Memory phase: request held until the ready cycle (dly), or timeout.
   task automatic add_mem(input int b, input int dly, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < MEM_TIMEOUT; i++) begin
         push(one(b) | one(B_BUSY), (i == dly), 1'b0);
         if (i == dly) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic add_inst(input int cls, input logic hlt, input int dly,
                           input bit first, output bit live);
      logic [12:0] bz;
      bit ok;
      bz    = one(B_BUSY);
      cur_t = 3'(cls);
      cur_h = hlt;
      live  = 1'b1;
      push(one(B_FETCH) | bz | (first ? one(B_PCL) : 13'd0), 1'b0, 1'b0);
      push(one(B_DEC) | bz, 1'b0, 1'b0);
      if (hlt) begin
         add_halted(1'b1);
         live = 1'b0;
      end else begin
         case (cls)
            1: begin
               push(one(B_RR) | bz, 1'b0, 1'b0);
               repeat (ALU_CYCLES) push(one(B_ALU) | bz, 1'b0, 1'b0);
               push(one(B_RW) | bz, 1'b0, 1'b0);
               model_ret++;
            end
            2: begin
               push(one(B_BR) | bz, 1'b0, 1'b0);
               model_ret++;
            end
            3: begin
               push(one(B_RW) | bz, 1'b0, 1'b0);
               model_ret++;
            end
            4: begin
               push(one(B_RR) | bz, 1'b0, 1'b0);
               push(one(B_BR) | bz, 1'b0, 1'b0);
               model_ret++;
            end
            5, 6: begin
               push(one(B_RR) | bz, 1'b0, 1'b0);
               add_mem((cls == 6) ? B_MR : B_MW, dly, ok);
               if (!ok) begin
                  add_halted(1'b0);
                  live = 1'b0;
               end else begin
                  if (cls == 6) push(one(B_RMW) | bz, 1'b0, 1'b0);
                  model_ret++;
               end
            end
            default: begin
               add_halted(1'b0);
               live = 1'b0;
            end
         endcase
      end
   endtask

   task automatic run_queue(input int n, input string tag);
      rec_t r;
      int   k;
      k = 0;
      while ((q.size() > 0) && ((n < 0) || (k < n))) begin
         r = q.pop_front();
         @(negedge clk);
         start     = r.start;
         mem_ready = r.rdy;
         inst_type = r.ityp;
         halt_inst = r.halt;
         #1;
         chk({tag, "_out"}, k, 16'(obs), 16'(r.exp));
         chk({tag, "_ret"}, k, retired, r.ret);
         k++;
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      init_n    = 1'b0;
      start     = 1'b0;
      mem_ready = 1'b0;
      halt_inst = 1'b0;
      #1;
      chk({tag, "_rst_out"}, 0, 16'(obs), 16'd0);
      chk({tag, "_rst_ret"}, 0, retired, 16'd0);
      repeat (2) @(negedge clk);
      init_n    = 1'b1;
      model_ret = 0;
      q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Program A: directed classes and memory boundaries, random stream,
      // then a store that never sees mem_ready.
      do_reset("A");
      start_addr = 9'h040;
      cur_t = 3'd3;
      push('0, 1'b0, 1'b0);
      push('0, 1'b0, 1'b1);
      add_inst(3, 1'b0, 0, 1'b1, alive);
      add_inst(1, 1'b0, 0, 1'b0, alive);
      add_inst(6, 1'b0, 4, 1'b0, alive);
      add_inst(5, 1'b0, 0, 1'b0, alive);
      add_inst(2, 1'b0, 0, 1'b0, alive);
      add_inst(4, 1'b0, 0, 1'b0, alive);
      add_inst(6, 1'b0, MEM_TIMEOUT - 1, 1'b0, alive);
      add_inst(5, 1'b0, 7, 1'b0, alive);
      for (int i = 0; i < 25; i++)
         add_inst(int'($urandom_range(1, 6)), 1'b0, int'($urandom_range(0, 8)),
                  1'b0, alive);
      add_inst(5, 1'b0, -1, 1'b0, alive);
      run_queue(-1, "progA");

      // Program B: two moves retire, then HALT overriding an ALU class.
      do_reset("B");
      push('0, 1'b0, 1'b1);
      add_inst(3, 1'b0, 0, 1'b1, alive);
      add_inst(3, 1'b0, 0, 1'b0, alive);
      add_inst(1, 1'b1, 0, 1'b0, alive);
      run_queue(-1, "progB");

      // Program C: random legal prefix ending in illegal class 7.
      do_reset("C");
      start_addr = 9'($urandom);
      push('0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++)
         add_inst(int'($urandom_range(1, 6)), 1'b0, int'($urandom_range(0, 5)),
                  (i == 0), alive);
      add_inst(7, 1'b0, 0, 1'b0, alive);
      run_queue(-1, "progC");

      // Program D: illegal class 0 as the very first instruction.
      do_reset("D");
      push('0, 1'b0, 1'b1);
      add_inst(0, 1'b0, 0, 1'b1, alive);
      run_queue(-1, "progD");

      // Program E: reset asserted while the ALU is being held.
      do_reset("E");
      push('0, 1'b0, 1'b1);
      add_inst(3, 1'b0, 0, 1'b1, alive);
      add_inst(1, 1'b0, 0, 1'b0, alive);
      run_queue(9, "progE");
      #1;
      init_n = 1'b0;
      #1;
      chk("exec_abort_out", 0, 16'(obs), 16'd0);
      chk("exec_abort_ret", 0, retired, 16'd0);
      q.delete();
      model_ret = 0;
      repeat (2) @(negedge clk);
      init_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("after_abort_idle", i, 16'(obs), 16'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
